gbt_pattern_gen_chk: RTL and testbench

Parametrised GBT link test-pattern generator and self-synchronising checker. It is the successor to the ad-hoc 32-bit frame counter and the received-data OR-reduction used to bring up the link. It produces a selectable pattern (counter, PRBS-31, walking-one or static) on the TX frame strobe. It checks the RX frame stream against the same pattern, with a lock FSM and saturating error statistics for link qualification and diagnostics.

---
 rtl/gbt_pattern_gen_chk.sv | 223 ++++++++++++++++++++++
 tb/tb_gbt_pattern_gen_chk.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbt_pattern_gen_chk.sv
// GBT link test-pattern generator and self-synchronising checker.
// TX side produces counter / PRBS-31 / walking-one / static words on each
// frame strobe. RX side predicts each word from the previously received one,
// locks after a run of good words and keeps saturating error statistics.
//
// Handshake: a word is transferred on every cycle where its valid strobe is
// high (tx_valid_i advances the generator, rx_valid_i presents a word to the
// checker). There is no ready/back-pressure; both sides accept every cycle.
module gbt_pattern_gen_chk #(
  parameter int DATA_W     = 64,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int ERRCNT_W   = 16
) (
  input  logic                clk_ik,
  input  logic                rst_irn,
  input  logic [1:0]          mode_i,
  input  logic [DATA_W-1:0]   static_i,
  input  logic                los_i,
  input  logic                tx_valid_i,
  output logic [DATA_W-1:0]   tx_data_o,
  input  logic                rx_valid_i,
  input  logic [DATA_W-1:0]   rx_data_i,
  input  logic                clr_err_i,
  output logic                lock_o,
  output logic [ERRCNT_W-1:0] err_cnt_o,
  output logic                err_flag_o
);

  localparam int REP = DATA_W / 32;
  localparam int GW  = $clog2(LOCK_CNT + 1);
  localparam int BW  = $clog2(UNLOCK_CNT + 1);

  localparam logic [1:0] M_CNT  = 2'b00;
  localparam logic [1:0] M_PRBS = 2'b01;
  localparam logic [1:0] M_WALK = 2'b10;

  typedef enum logic {HUNT, LOCKED} state_t;

  // One full word of x^31+x^28+1; first generated bit lands in the MSB.
  function automatic logic [DATA_W-1:0] prbs_word(input logic [30:0] seed);
    logic [30:0]       s;
    logic              n;
    logic [DATA_W-1:0] w;
    s = seed;
    w = '0;
    for (int i = 0; i < DATA_W; i++) begin
      n = s[30] ^ s[27];
      s = {s[29:0], n};
      w[DATA_W-1-i] = n;
    end
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] x);
    return {x[DATA_W-2:0], x[DATA_W-1]};
  endfunction

  logic [1:0]        mode_q;
  logic              mode_chg;
  logic [31:0]       cnt;
  logic [30:0]       lfsr;
  logic [DATA_W-1:0] walk;
  logic [DATA_W-1:0] gen_word;

  logic              prev_valid;
  logic [DATA_W-1:0] rx_prev;
  logic [DATA_W-1:0] exp_word;
  logic              zero_bad;
  logic              good;
  logic              compare;

  state_t            state, state_next;
  logic [GW-1:0]     good_run, good_next;
  logic [BW-1:0]     bad_run, bad_next;
  logic              err_inc;

  assign mode_chg = (mode_q != mode_i);

  // Remember the mode so a change can restart both generator and checker.
  always_ff @(posedge clk_ik or negedge rst_irn) begin
    if (!rst_irn) mode_q <= M_CNT;
    else          mode_q <= mode_i;
  end

  // Word the generator emits on the next strobe.
  always_comb begin
    gen_word = static_i;
    case (mode_i)
      M_CNT:   gen_word = {REP{cnt}};
      M_PRBS:  gen_word = prbs_word(lfsr);
      M_WALK:  gen_word = walk;
      default: gen_word = static_i;
    endcase
  end

  // Generator state and registered TX word; LOS parks it at the start.
  always_ff @(posedge clk_ik or negedge rst_irn) begin
    if (!rst_irn) begin
      cnt       <= '0;
      lfsr      <= '1;
      walk      <= DATA_W'(1);
      tx_data_o <= '0;
    end else if (los_i) begin
      cnt       <= '0;
      lfsr      <= '1;
      walk      <= DATA_W'(1);
      tx_data_o <= '0;
    end else if (mode_chg) begin
      cnt       <= '0;
      lfsr      <= '1;
      walk      <= DATA_W'(1);
    end else if (tx_valid_i) begin
      tx_data_o <= gen_word;
      case (mode_i)
        M_CNT:   cnt  <= cnt + 32'd1;
        M_PRBS:  lfsr <= gen_word[30:0];
        M_WALK:  walk <= rotl1(walk);
        default: ;
      endcase
    end
  end

  // Prediction of the current RX word from the previous one.
  always_comb begin
    exp_word = static_i;
    case (mode_i)
      M_CNT:   exp_word = {REP{rx_prev[31:0] + 32'd1}};
      M_PRBS:  exp_word = prbs_word(rx_prev[30:0]);
      M_WALK:  exp_word = rotl1(rx_prev);
      default: exp_word = static_i;
    endcase
  end

  // All-zero input must never look good, or a dead link could lock.
  assign zero_bad = ((mode_i == M_PRBS) || (mode_i == M_WALK)) && (rx_data_i == '0);
  assign good     = (rx_data_i == exp_word) && !zero_bad;
  assign compare  = rx_valid_i && prev_valid && !los_i && !mode_chg;

  // Previous-word store; the first word after a restart only seeds it.
  always_ff @(posedge clk_ik or negedge rst_irn) begin
    if (!rst_irn) begin
      prev_valid <= 1'b0;
      rx_prev    <= '0;
    end else if (los_i || mode_chg) begin
      prev_valid <= 1'b0;
    end else if (rx_valid_i) begin
      prev_valid <= 1'b1;
      rx_prev    <= rx_data_i;
    end
  end

  // Lock FSM next-state, run counters and error-increment decode.
  always_comb begin
    state_next = state;
    good_next  = good_run;
    bad_next   = bad_run;
    err_inc    = 1'b0;
    if (los_i || mode_chg) begin
      state_next = HUNT;
      good_next  = '0;
      bad_next   = '0;
    end else if (compare) begin
      case (state)
        HUNT: begin
          if (!good) begin
            good_next = '0;
          end else if (good_run == GW'(LOCK_CNT - 1)) begin
            state_next = LOCKED;
            good_next  = '0;
            bad_next   = '0;
          end else begin
            good_next = good_run + GW'(1);
          end
        end
        default: begin
          if (good) begin
            bad_next = '0;
          end else begin
            err_inc = 1'b1;
            if (bad_run == BW'(UNLOCK_CNT - 1)) begin
              state_next = HUNT;
              good_next  = '0;
              bad_next   = '0;
            end else begin
              bad_next = bad_run + BW'(1);
            end
          end
        end
      endcase
    end
  end

  // Lock FSM state and run counter registers.
  always_ff @(posedge clk_ik or negedge rst_irn) begin
    if (!rst_irn) begin
      state    <= HUNT;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      state    <= state_next;
      good_run <= good_next;
      bad_run  <= bad_next;
    end
  end

  // Saturating error counter and sticky flag; clear wins over increment.
  always_ff @(posedge clk_ik or negedge rst_irn) begin
    if (!rst_irn) begin
      err_cnt_o  <= '0;
      err_flag_o <= 1'b0;
    end else if (clr_err_i) begin
      err_cnt_o  <= '0;
      err_flag_o <= 1'b0;
    end else if (err_inc) begin
      err_flag_o <= 1'b1;
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERRCNT_W'(1);
    end
  end

  assign lock_o = (state == LOCKED);

endmodule

// File: tb/tb_gbt_pattern_gen_chk.sv
// Directed bench for gbt_pattern_gen_chk: counter loopback lock, single-bit
// corruption, forced unlock/relock, LOS, async reset, PRBS-31, walking-one,
// static, and error-counter saturation on a narrow second instance.
module tb_gbt_pattern_gen_chk;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance (defaults: 64-bit, lock 16, unlock 4, 16-bit errors)
  logic [1:0]  mode;
  logic [63:0] static_v;
  logic        los;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic        clr;
  logic        lock;
  logic [15:0] err_cnt;
  logic        err_flag;

  // saturation instance (32-bit, 4-bit errors, unlock effectively disabled)
  logic [1:0]  s_mode;
  logic [31:0] s_static;
  logic        s_los;
  logic        s_tx_valid;
  logic [31:0] s_tx_data;
  logic        s_rx_valid;
  logic [31:0] s_rx_data;
  logic        s_clr;
  logic        s_lock;
  logic [3:0]  s_err_cnt;
  logic        s_err_flag;

  gbt_pattern_gen_chk dut (
    .clk_ik(clk), .rst_irn(rst_n), .mode_i(mode), .static_i(static_v),
    .los_i(los), .tx_valid_i(tx_valid), .tx_data_o(tx_data),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .clr_err_i(clr),
    .lock_o(lock), .err_cnt_o(err_cnt), .err_flag_o(err_flag)
  );

  gbt_pattern_gen_chk #(.DATA_W(32), .LOCK_CNT(16), .UNLOCK_CNT(100), .ERRCNT_W(4)) dut_s (
    .clk_ik(clk), .rst_irn(rst_n), .mode_i(s_mode), .static_i(s_static),
    .los_i(s_los), .tx_valid_i(s_tx_valid), .tx_data_o(s_tx_data),
    .rx_valid_i(s_rx_valid), .rx_data_i(s_rx_data), .clr_err_i(s_clr),
    .lock_o(s_lock), .err_cnt_o(s_err_cnt), .err_flag_o(s_err_flag)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // PRBS-31 reference as a continuous bit stream b[k] = b[k-31] ^ b[k-28],
  // seeded with 31 ones; each 64-bit word is the next 64 stream bits, MSB first.
  task automatic build_prbs_ref(input int nwords);
    bit b[];
    logic [63:0] w;
    b = new[31 + 64 * nwords];
    for (int k = 0; k < 31; k++) b[k] = 1'b1;
    for (int k = 31; k < 31 + 64 * nwords; k++) b[k] = b[k-31] ^ b[k-28];
    for (int n = 0; n < nwords; n++) begin
      for (int t = 0; t < 64; t++) w[63-t] = b[31 + 64 * n + t];
      exp_q.push_back(w);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one frame with TX looped back into RX, optionally corrupted.
  task automatic loop_step(input logic [63:0] flip);
    tick();
    rx_data  = tx_data ^ flip;
    rx_valid = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; mode = 2'b00; static_v = '0; los = 1'b0;
    tx_valid = 1'b0; rx_valid = 1'b0; rx_data = '0; clr = 1'b0;
    s_mode = 2'b00; s_static = '0; s_los = 1'b0;
    s_tx_valid = 1'b0; s_rx_valid = 1'b0; s_rx_data = '0; s_clr = 1'b0;
    build_prbs_ref(2);

    #12;
    chk("rst_tx", tx_data, 64'h0);
    chk("rst_lock", {63'h0, lock}, 64'h0);
    chk("rst_err", {48'h0, err_cnt}, 64'h0);
    chk("rst_flag", {63'h0, err_flag}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // counter loopback: lock after 17 RX words
    tx_valid = 1'b1;
    tick();
    chk("cnt_w0", tx_data, 64'h0);
    rx_data = tx_data; rx_valid = 1'b1;
    loop_step('0);
    chk("cnt_w1", tx_data, 64'h00000001_00000001);
    repeat (15) loop_step('0);
    chk("cnt_nolock_16", {63'h0, lock}, 64'h0);
    loop_step('0);
    chk("cnt_lock_17", {63'h0, lock}, 64'h1);
    chk("cnt_err0", {48'h0, err_cnt}, 64'h0);
    chk("cnt_w17", tx_data, 64'h00000011_00000011);

    // single bit-5 flip: corrupted word and its successor both mismatch
    loop_step(64'h20);
    repeat (3) loop_step('0);
    chk("flip_err2", {48'h0, err_cnt}, 64'd2);
    chk("flip_flag", {63'h0, err_flag}, 64'h1);
    chk("flip_lock", {63'h0, lock}, 64'h1);

    // clear statistics, lock is unaffected
    clr = 1'b1;
    loop_step('0);
    clr = 1'b0;
    chk("clr_err", {48'h0, err_cnt}, 64'h0);
    chk("clr_flag", {63'h0, err_flag}, 64'h0);
    chk("clr_lock", {63'h0, lock}, 64'h1);

    // four consecutive bad words drop lock
    repeat (4) begin
      tick();
      rx_data = 64'hDEADBEEF_DEADBEEF;
    end
    chk("bad3_lock", {63'h0, lock}, 64'h1);
    chk("bad3_err", {48'h0, err_cnt}, 64'd3);
    loop_step('0);
    chk("bad4_unlock", {63'h0, lock}, 64'h0);
    chk("bad4_err", {48'h0, err_cnt}, 64'd4);
    chk("bad4_flag", {63'h0, err_flag}, 64'h1);
    // first clean word mismatches the garbage base, then 16 good relock
    repeat (16) loop_step('0);
    chk("relock_not_yet", {63'h0, lock}, 64'h0);
    chk("hunt_no_count", {48'h0, err_cnt}, 64'd4);
    loop_step('0);
    chk("relock", {63'h0, lock}, 64'h1);

    // loss of signal mid-stream
    los = 1'b1; rx_valid = 1'b0;
    tick();
    chk("los_tx", tx_data, 64'h0);
    chk("los_lock", {63'h0, lock}, 64'h0);
    tick();
    chk("los_err_kept", {48'h0, err_cnt}, 64'd4);
    los = 1'b0;
    tick();
    chk("los_w0", tx_data, 64'h0);
    rx_data = tx_data; rx_valid = 1'b1;
    loop_step('0);
    chk("los_w1", tx_data, 64'h00000001_00000001);
    repeat (16) loop_step('0);
    chk("los_relock", {63'h0, lock}, 64'h1);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", tx_data, 64'h0);
    chk("arst_lock", {63'h0, lock}, 64'h0);
    chk("arst_err", {48'h0, err_cnt}, 64'h0);
    chk("arst_flag", {63'h0, err_flag}, 64'h0);
    tx_valid = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tx_valid = 1'b1;
    tick();
    tick();
    chk("arst_restart_w1", tx_data, 64'h00000001_00000001);

    // PRBS-31 loopback
    tx_valid = 1'b0; mode = 2'b01;
    tick();
    tick();
    tx_valid = 1'b1;
    tick();
    chk("prbs_w0_hand", tx_data, 64'h0000000E_000000FC);
    chk("prbs_w0_model", tx_data, exp_q.pop_front());
    rx_data = tx_data; rx_valid = 1'b1;
    loop_step('0);
    chk("prbs_w1_model", tx_data, exp_q.pop_front());
    repeat (15) loop_step('0);
    chk("prbs_nolock_16", {63'h0, lock}, 64'h0);
    loop_step('0);
    chk("prbs_lock_17", {63'h0, lock}, 64'h1);

    // stuck-zero input: unlock and never relock
    repeat (5) begin
      tick();
      rx_data = '0;
    end
    chk("zero_unlock", {63'h0, lock}, 64'h0);
    chk("zero_err4", {48'h0, err_cnt}, 64'd4);
    repeat (30) begin
      tick();
      chk("zero_nolock", {63'h0, lock}, 64'h0);
    end

    // walking-one
    tx_valid = 1'b0; rx_valid = 1'b0; mode = 2'b10;
    tick();
    tick();
    tx_valid = 1'b1;
    tick();
    chk("walk_w0", tx_data, 64'h1);
    tick();
    chk("walk_w1", tx_data, 64'h2);
    tick();
    chk("walk_w2", tx_data, 64'h4);

    // static
    tx_valid = 1'b0; mode = 2'b11; static_v = 64'hA5A5_0F0F_1234_5678;
    tick();
    tick();
    tx_valid = 1'b1;
    tick();
    chk("static_w", tx_data, 64'hA5A5_0F0F_1234_5678);
    tx_valid = 1'b0;

    // saturation on the 4-bit counter instance
    s_tx_valid = 1'b1;
    tick();
    s_rx_data = s_tx_data; s_rx_valid = 1'b1;
    repeat (17) begin
      tick();
      s_rx_data = s_tx_data;
    end
    chk("sat_lock", {63'h0, s_lock}, 64'h1);
    repeat (20) begin
      tick();
      s_rx_data = 32'hDEADBEEF;
    end
    tick();
    chk("sat_err15", {60'h0, s_err_cnt}, 64'd15);
    chk("sat_still_locked", {63'h0, s_lock}, 64'h1);
    s_clr = 1'b1;
    tick();
    chk("sat_clr_wins", {60'h0, s_err_cnt}, 64'h0);
    s_clr = 1'b0;
    tick();
    chk("sat_after_clr", {60'h0, s_err_cnt}, 64'd1);
    chk("sat_flag", {63'h0, s_err_flag}, 64'h1);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
